// File: rtl/mure_pkg.sv
// Shared widths and transaction types for the retirement/trace front end.
// Only the fields consumed by the trace encoder are carried here.
package mure_pkg;

    localparam int XLEN        = 32;
    localparam int PRIV_LEN    = 2;
    localparam int CAUSE_LEN   = 32;
    localparam int ITYPE_LEN   = 3;
    localparam int IRETIRE_LEN = 2;

    typedef enum logic [3:0] {
        ADD, SUB, ANDL, ORL,
        EQ, NE, LTS, GES, LTU, GEU,
        JAL, JALR, MRET, SRET, DRET, LOAD
    } fu_op_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        fu_op_t          op;
        logic            is_compressed;
    } scoreboard_entry_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            is_taken;
    } bp_resolve_t;

    typedef struct packed {
        logic                 valid;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
    } exception_t;

endpackage

// File: rtl/multiple_retirement.sv
// Converts NRET committing instructions per cycle into E-Trace retirement blocks.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; every cycle's commit is accepted and reported.
module multiple_retirement
    import mure_pkg::*;
#(
    parameter int NRET = 2,
    parameter int N    = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NRET-1:0]                  valid_i,
    input  scoreboard_entry_t [NRET-1:0]     commit_instr_i,
    input  bp_resolve_t                      resolved_branch_i,
    input  exception_t                       exception_i,
    input  logic                             interrupt_i,
    input  logic [PRIV_LEN-1:0]              priv_lvl_i,
    output logic [N-1:0]                     valid_o,
    output logic [N*IRETIRE_LEN-1:0]         iretire_o,
    output logic [N-1:0]                     ilastsize_o,
    output logic [N*ITYPE_LEN-1:0]           itype_o,
    output logic [CAUSE_LEN-1:0]             cause_o,
    output logic [XLEN-1:0]                  tval_o,
    output logic [PRIV_LEN-1:0]              priv_o,
    output logic [N*XLEN-1:0]                iaddr_o
);

    localparam logic [ITYPE_LEN-1:0] IT_NONE   = 3'd0;
    localparam logic [ITYPE_LEN-1:0] IT_EXC    = 3'd1;
    localparam logic [ITYPE_LEN-1:0] IT_INT    = 3'd2;
    localparam logic [ITYPE_LEN-1:0] IT_RET    = 3'd3;
    localparam logic [ITYPE_LEN-1:0] IT_NTAKEN = 3'd4;
    localparam logic [ITYPE_LEN-1:0] IT_TAKEN  = 3'd5;
    localparam logic [ITYPE_LEN-1:0] IT_UNINF  = 3'd6;

    // Most recent branch resolution, used when the branch commits after resolving.
    logic [XLEN-1:0] bp_pc_q;
    logic            bp_taken_q;

    logic [N-1:0]             valid_d;
    logic [N*IRETIRE_LEN-1:0] iretire_d;
    logic [N-1:0]             ilastsize_d;
    logic [N*ITYPE_LEN-1:0]   itype_d;
    logic [CAUSE_LEN-1:0]     cause_d;
    logic [XLEN-1:0]          tval_d;
    logic [N*XLEN-1:0]        iaddr_d;
    logic                     exc_rpt;

    function automatic logic branch_taken(
        input logic [XLEN-1:0] pc,
        input bp_resolve_t     rb,
        input logic [XLEN-1:0] st_pc,
        input logic            st_taken
    );
        logic taken;
        // A same-cycle resolution is newer than the stored one.
        if (rb.valid && (rb.pc == pc)) begin
            taken = rb.is_taken;
        end else begin
            taken = (st_pc == pc) && st_taken;
        end
        return taken;
    endfunction

    always_comb begin
        valid_d     = '0;
        iretire_d   = '0;
        ilastsize_d = '0;
        itype_d     = '0;
        cause_d     = '0;
        tval_d      = '0;
        iaddr_d     = '0;
        exc_rpt     = valid_i[0] && exception_i.valid;

        if (exc_rpt) begin
            cause_d = exception_i.cause;
            tval_d  = exception_i.tval;
        end

        for (int k = 0; k < NRET; k++) begin
            // The trapping instruction ends the packet; younger ports are dropped.
            if (valid_i[k] && !(exc_rpt && (k != 0))) begin
                valid_d[k]                           = 1'b1;
                iaddr_d[k*XLEN +: XLEN]              = commit_instr_i[k].pc;
                iretire_d[k*IRETIRE_LEN +: IRETIRE_LEN] =
                    commit_instr_i[k].is_compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
                ilastsize_d[k]                       = !commit_instr_i[k].is_compressed;

                if ((k == 0) && exc_rpt) begin
                    itype_d[k*ITYPE_LEN +: ITYPE_LEN] = interrupt_i ? IT_INT : IT_EXC;
                end else begin
                    unique case (commit_instr_i[k].op)
                        MRET, SRET, DRET:
                            itype_d[k*ITYPE_LEN +: ITYPE_LEN] = IT_RET;
                        EQ, NE, LTS, GES, LTU, GEU:
                            itype_d[k*ITYPE_LEN +: ITYPE_LEN] =
                                branch_taken(commit_instr_i[k].pc, resolved_branch_i,
                                             bp_pc_q, bp_taken_q) ? IT_TAKEN : IT_NTAKEN;
                        JALR:
                            itype_d[k*ITYPE_LEN +: ITYPE_LEN] = IT_UNINF;
                        default:
                            itype_d[k*ITYPE_LEN +: ITYPE_LEN] = IT_NONE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            valid_o     <= '0;
            iretire_o   <= '0;
            ilastsize_o <= '0;
            itype_o     <= '0;
            cause_o     <= '0;
            tval_o      <= '0;
            priv_o      <= '0;
            iaddr_o     <= '0;
            bp_pc_q     <= '0;
            bp_taken_q  <= 1'b0;
        end else begin
            valid_o     <= valid_d;
            iretire_o   <= iretire_d;
            ilastsize_o <= ilastsize_d;
            itype_o     <= itype_d;
            cause_o     <= cause_d;
            tval_o      <= tval_d;
            priv_o      <= priv_lvl_i;
            iaddr_o     <= iaddr_d;
            if (resolved_branch_i.valid) begin
                bp_pc_q    <= resolved_branch_i.pc;
                bp_taken_q <= resolved_branch_i.is_taken;
            end
        end
    end

endmodule

// File: tb/tb_multiple_retirement.sv
// Bench for multiple_retirement: expected output words are queued when a cycle is
// driven and popped after the following clock edge.
module tb_multiple_retirement;
    import mure_pkg::*;

    localparam int OW = 2 + 4 + 2 + 6 + 32 + 32 + 2 + 64;
    typedef logic [OW-1:0] exp_t;

    logic                         clk;
    logic                         rst_ni;
    logic [1:0]                   valid_i;
    scoreboard_entry_t [1:0]      commit_instr_i;
    bp_resolve_t                  resolved_branch_i;
    exception_t                   exception_i;
    logic                         interrupt_i;
    logic [1:0]                   priv_lvl_i;
    logic [1:0]                   valid_o;
    logic [3:0]                   iretire_o;
    logic [1:0]                   ilastsize_o;
    logic [5:0]                   itype_o;
    logic [31:0]                  cause_o;
    logic [31:0]                  tval_o;
    logic [1:0]                   priv_o;
    logic [63:0]                  iaddr_o;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    multiple_retirement #(.NRET(2), .N(2)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .valid_i           (valid_i),
        .commit_instr_i    (commit_instr_i),
        .resolved_branch_i (resolved_branch_i),
        .exception_i       (exception_i),
        .interrupt_i       (interrupt_i),
        .priv_lvl_i        (priv_lvl_i),
        .valid_o           (valid_o),
        .iretire_o         (iretire_o),
        .ilastsize_o       (ilastsize_o),
        .itype_o           (itype_o),
        .cause_o           (cause_o),
        .tval_o            (tval_o),
        .priv_o            (priv_o),
        .iaddr_o           (iaddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic exp_t mk(input logic [1:0] v, input logic [3:0] iret,
                                input logic [1:0] ils, input logic [5:0] ity,
                                input logic [31:0] cause, input logic [31:0] tval,
                                input logic [1:0] priv, input logic [63:0] iaddr);
        return {v, iret, ils, ity, cause, tval, priv, iaddr};
    endfunction

    function automatic exp_t got();
        return {valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o};
    endfunction

    task automatic clear_inputs();
        rst_ni            = 1'b0;
        valid_i           = 2'b00;
        commit_instr_i    = '0;
        resolved_branch_i = '0;
        exception_i       = '0;
        interrupt_i       = 1'b0;
        priv_lvl_i        = 2'd0;
    endtask

    task automatic set_port(input int k, input logic [31:0] pc, input fu_op_t op, input logic c);
        commit_instr_i[k].pc            = pc;
        commit_instr_i[k].op            = op;
        commit_instr_i[k].is_compressed = c;
        valid_i[k]                      = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            rst_ni = 1'b1;
            set_port(0, 32'h1000, ADD, 1'b0);
            set_port(1, 32'h1004, JALR, 1'b1);
            resolved_branch_i = '{valid: 1'b1, pc: 32'h1000, is_taken: 1'b1};
            priv_lvl_i = 2'd3;
            sb.push_back('0);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (got() !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h required %h", i, got(), e);
            end
        end
    endtask

    task automatic test_basic();
        exp_t e;
        clear_inputs();
        set_port(0, 32'h8000_0000, ADD, 1'b0);
        set_port(1, 32'h8000_0004, SUB, 1'b1);
        sb.push_back(mk(2'b11, 4'b01_10, 2'b01, 6'o00, 0, 0, 0, {32'h8000_0004, 32'h8000_0000}));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (got() !== e) begin
            n_fail++;
            $display("FAIL basic_two_ports: got %h required %h", got(), e);
        end

        // Only port 1 valid; port 0 fields must read back as zero.
        clear_inputs();
        set_port(0, 32'h2222_0000, JALR, 1'b0);
        set_port(1, 32'h3333_0002, LOAD, 1'b1);
        valid_i = 2'b10;
        sb.push_back(mk(2'b10, 4'b01_00, 2'b00, 6'o00, 0, 0, 0, {32'h3333_0002, 32'h0}));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (got() !== e) begin
            n_fail++;
            $display("FAIL basic_port1_only: got %h required %h", got(), e);
        end
    endtask

    task automatic test_branch_stored(input logic taken);
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            if (c == 0) resolved_branch_i = '{valid: 1'b1, pc: 32'h100, is_taken: taken};
            if (c == 2) begin
                set_port(0, 32'h100, EQ, 1'b0);
                sb.push_back(mk(2'b01, 4'b00_10, 2'b01, {3'd0, taken ? 3'd5 : 3'd4},
                                0, 0, 0, {32'h0, 32'h100}));
            end else begin
                sb.push_back('0);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (got() !== e) begin
                n_fail++;
                $display("FAIL branch_stored(taken=%0b) cycle %0d: got %h required %h",
                         taken, c, got(), e);
            end
        end
    endtask

    task automatic test_branch_bypass();
        exp_t e;
        // Stored record is {0x100, not taken}; bypass says taken for port 1, port 0 misses.
        clear_inputs();
        resolved_branch_i = '{valid: 1'b1, pc: 32'h100, is_taken: 1'b1};
        set_port(0, 32'h104, LTU, 1'b0);
        set_port(1, 32'h100, NE, 1'b1);
        sb.push_back(mk(2'b11, 4'b01_10, 2'b01, 6'o54, 0, 0, 0, {32'h100, 32'h104}));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (got() !== e) begin
            n_fail++;
            $display("FAIL branch_bypass_taken: got %h required %h", got(), e);
        end

        // Stored record is now {0x100, taken}; a same-cycle not-taken overrides it.
        clear_inputs();
        resolved_branch_i = '{valid: 1'b1, pc: 32'h100, is_taken: 1'b0};
        set_port(0, 32'h100, GEU, 1'b0);
        sb.push_back(mk(2'b01, 4'b00_10, 2'b01, 6'o04, 0, 0, 0, {32'h0, 32'h100}));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (got() !== e) begin
            n_fail++;
            $display("FAIL branch_bypass_priority: got %h required %h", got(), e);
        end
    endtask

    task automatic test_exception();
        exp_t e;
        for (int irq = 0; irq < 2; irq++) begin
            clear_inputs();
            set_port(0, 32'h200, ADD, 1'b0);
            set_port(1, 32'h204, JALR, 1'b1);
            exception_i = '{valid: 1'b1, cause: 32'd2, tval: 32'hDEAD};
            interrupt_i = irq[0];
            sb.push_back(mk(2'b01, 4'b00_10, 2'b01, {3'd0, irq[0] ? 3'd2 : 3'd1},
                            32'd2, 32'hDEAD, 0, {32'h0, 32'h200}));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (got() !== e) begin
                n_fail++;
                $display("FAIL exception(irq=%0d): got %h required %h", irq, got(), e);
            end
        end

        // Exception flagged with no valid commit is not reported.
        clear_inputs();
        exception_i = '{valid: 1'b1, cause: 32'd7, tval: 32'hBEEF};
        sb.push_back('0);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (got() !== e) begin
            n_fail++;
            $display("FAIL exception_no_commit: got %h required %h", got(), e);
        end
    endtask

    task automatic test_ret_jump();
        exp_t e;
        clear_inputs();
        set_port(0, 32'h300, MRET, 1'b0);
        set_port(1, 32'h304, JALR, 1'b0);
        priv_lvl_i = 2'd3;
        sb.push_back(mk(2'b11, 4'b10_10, 2'b11, 6'o63, 0, 0, 2'd3, {32'h304, 32'h300}));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (got() !== e) begin
            n_fail++;
            $display("FAIL mret_jalr_priv: got %h required %h", got(), e);
        end

        clear_inputs();
        set_port(0, 32'h400, SRET, 1'b1);
        set_port(1, 32'h402, DRET, 1'b0);
        priv_lvl_i = 2'd1;
        sb.push_back(mk(2'b11, 4'b10_01, 2'b10, 6'o33, 0, 0, 2'd1, {32'h402, 32'h400}));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (got() !== e) begin
            n_fail++;
            $display("FAIL sret_dret: got %h required %h", got(), e);
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            case (c)
                0: begin
                    resolved_branch_i = '{valid: 1'b1, pc: 32'h400, is_taken: 1'b1};
                    set_port(0, 32'h500, ADD, 1'b0);
                    sb.push_back(mk(2'b01, 4'b00_10, 2'b01, 6'o00, 0, 0, 0, {32'h0, 32'h500}));
                end
                1: begin
                    rst_ni = 1'b1;
                    set_port(0, 32'h504, ADD, 1'b0);
                    set_port(1, 32'h508, MRET, 1'b1);
                    exception_i = '{valid: 1'b1, cause: 32'd5, tval: 32'h1234};
                    priv_lvl_i = 2'd3;
                    sb.push_back('0);
                end
                default: begin
                    // Branch at the pc recorded before reset must now be not-taken.
                    set_port(0, 32'h400, EQ, 1'b0);
                    sb.push_back(mk(2'b01, 4'b00_10, 2'b01, 6'o04, 0, 0, 0, {32'h0, 32'h400}));
                end
            endcase
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (got() !== e) begin
                n_fail++;
                $display("FAIL reset_midstream cycle %0d: got %h required %h", c, got(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] pc;
            logic        cmp;
            pc  = 32'h9000 + 32'(i * 8);
            cmp = i[0];
            clear_inputs();
            set_port(0, pc, ADD, cmp);
            set_port(1, pc + 32'h4, JALR, ~cmp);
            priv_lvl_i = i[1:0];
            sb.push_back(mk(2'b11, {cmp ? 2'd2 : 2'd1, cmp ? 2'd1 : 2'd2}, {cmp, ~cmp},
                            6'o60, 0, 0, i[1:0], {pc + 32'h4, pc}));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (got() !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h required %h", i, got(), e);
            end
        end
    endtask

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_basic();
        test_branch_stored(1'b1);
        test_branch_stored(1'b0);
        test_branch_bypass();
        test_exception();
        test_ret_jump();
        test_reset_midstream();
        test_back_to_back();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
